// File: rtl/dbus_arbiter_if.sv
// Two-master / one-slave data-bus bundle. The arbiter takes the slave modport
// (it serves the masters and drives the shared slave request).
interface dbus_arbiter_if;
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        s_req, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic [1:0]  owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  s_ack, s_rdata,
    output m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
    output s_req, s_we, s_addr, s_wdata, s_be, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output s_ack, s_rdata,
    input  m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
    input  s_req, s_we, s_addr, s_wdata, s_be, owner
  );
endinterface

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter between the core D-bus (m0) and debug SBA (m1) onto one
// slave port, with a bounded slave wait that turns into an error response.
module dbus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  dbus_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic [1:0]        owner_q, owner_d;
  logic              s_we_q, s_we_d;
  logic [31:0]       s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [3:0]        s_be_q, s_be_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0][31:0]  rdata_q, rdata_d;

  logic [1:0]        req, we;
  logic [1:0][31:0]  addr, wdata;
  logic [1:0][3:0]   be;
  logic [CW:0]       cnt_inc;
  logic              timeout_hit;

  assign req   = {bus.m1_req,   bus.m0_req};
  assign we    = {bus.m1_we,    bus.m0_we};
  assign addr  = {bus.m1_addr,  bus.m0_addr};
  assign wdata = {bus.m1_wdata, bus.m0_wdata};
  assign be    = {bus.m1_be,    bus.m0_be};

  // One extra bit so the compare against TIMEOUT cannot wrap.
  assign cnt_inc     = {1'b0, cnt_q} + (CW+1)'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == (CW+1)'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: if (|req) begin
        // On a tie the master that was not served last wins.
        gnt_d     = (&req) ? ~last_q : req[1];
        last_d    = gnt_d;
        owner_d   = gnt_d ? 2'b10 : 2'b01;
        s_we_d    = we[gnt_d];
        s_addr_d  = addr[gnt_d];
        s_wdata_d = wdata[gnt_d];
        s_be_d    = be[gnt_d];
        cnt_d     = '0;
        state_d   = BUSY;
      end
      BUSY: if (bus.s_ack) begin
        rdata_d[gnt_q] = bus.s_rdata;
        err_d          = 1'b0;
        state_d        = RESP;
      end else if (timeout_hit) begin
        rdata_d[gnt_q] = '0;
        err_d          = 1'b1;
        state_d        = RESP;
      end else begin
        cnt_d = cnt_inc[CW-1:0];
      end
      RESP: begin
        owner_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      owner_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.s_req    = (state_q == BUSY);
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_be     = s_be_q;
  assign bus.owner    = owner_q;
  assign bus.m0_ack   = (state_q == RESP) && !gnt_q;
  assign bus.m1_ack   = (state_q == RESP) &&  gnt_q;
  assign bus.m0_err   = bus.m0_ack && err_q;
  assign bus.m1_err   = bus.m1_ack && err_q;
  assign bus.m0_rdata = rdata_q[0];
  assign bus.m1_rdata = rdata_q[1];
endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level
// model of arbitration order, slave-wait length and timeout outcome.
module tb_dbus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  dbus_arbiter_if bus();

  dbus_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
    bus.s_ack = 0; bus.s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({bus.s_req, bus.owner} !== 3'b000)
      $display("FAIL reset_sreq_owner: got %b want 000", {bus.s_req, bus.owner}); else passed++;
    total++; if ({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err} !== 4'b0000)
      $display("FAIL reset_ack_err: got %b want 0000", {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err}); else passed++;
    total++; if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h want 0", {bus.m0_rdata, bus.m1_rdata}); else passed++;
    total++; if ({bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be} !== 69'h0)
      $display("FAIL reset_sbus: got %h want 0", {bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.s_req !== 1'b0)
      $display("FAIL reset_release_idle: got %b want 0", bus.s_req); else passed++;
  endtask

  task automatic test_single_read();
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h100; bus.m0_be = 4'hf;
    @(negedge clk);
    total++; if ({bus.s_req, bus.owner, bus.s_we, bus.s_addr} !== {1'b1, 2'b01, 1'b0, 32'h100})
      $display("FAIL read_sbus: got %h want %h", {bus.s_req, bus.owner, bus.s_we, bus.s_addr}, {1'b1, 2'b01, 1'b0, 32'h100}); else passed++;
    @(negedge clk);
    total++; if ({bus.s_req, bus.m0_ack} !== 2'b10)
      $display("FAIL read_wait: got %b want 10", {bus.s_req, bus.m0_ack}); else passed++;
    bus.s_ack = 1; bus.s_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++; if ({bus.m0_ack, bus.m0_err, bus.m1_ack} !== 3'b100)
      $display("FAIL read_ack: got %b want 100", {bus.m0_ack, bus.m0_err, bus.m1_ack}); else passed++;
    total++; if (bus.m0_rdata !== 32'hCAFEF00D)
      $display("FAIL read_rdata: got %h want cafef00d", bus.m0_rdata); else passed++;
    idle_inputs();
    @(negedge clk);
    total++; if ({bus.s_req, bus.owner, bus.m0_ack} !== 4'b0000)
      $display("FAIL read_back_idle: got %b want 0000", {bus.s_req, bus.owner, bus.m0_ack}); else passed++;
  endtask

  task automatic test_round_robin();
    logic       exp_m;
    logic [1:0] oh;
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h1000;
    bus.m1_req = 1; bus.m1_addr = 32'h2000;
    bus.s_ack  = 1;
    for (int i = 0; i < 4; i++) begin
      exp_m = i[0];
      oh    = {exp_m, ~exp_m};
      @(negedge clk);
      total++; if ({bus.owner, bus.s_addr} !== {oh, exp_m ? 32'h2000 : 32'h1000})
        $display("FAIL rr_grant%0d: got %h want %h", i, {bus.owner, bus.s_addr}, {oh, exp_m ? 32'h2000 : 32'h1000}); else passed++;
      bus.s_rdata = 32'h100 + 32'(i);
      @(negedge clk);
      total++; if ({bus.m1_ack, bus.m0_ack} !== oh)
        $display("FAIL rr_ack%0d: got %b want %b", i, {bus.m1_ack, bus.m0_ack}, oh); else passed++;
      total++; if ((exp_m ? bus.m1_rdata : bus.m0_rdata) !== 32'h100 + 32'(i))
        $display("FAIL rr_rdata%0d: got %h want %h", i, exp_m ? bus.m1_rdata : bus.m0_rdata, 32'h100 + 32'(i)); else passed++;
      @(negedge clk);
      total++; if (bus.owner !== 2'b00)
        $display("FAIL rr_owner_idle%0d: got %b want 00", i, bus.owner); else passed++;
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_write();
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h40; bus.m1_wdata = 32'h12345678; bus.m1_be = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be, bus.owner} !== {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011, 2'b10})
        $display("FAIL write_sbus%0d: got %h want %h", k, {bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be, bus.owner},
                 {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011, 2'b10}); else passed++;
      bus.s_ack = (k == 2);
    end
    @(negedge clk);
    total++; if ({bus.m1_ack, bus.m1_err, bus.m0_ack} !== 3'b100)
      $display("FAIL write_ack: got %b want 100", {bus.m1_ack, bus.m1_err, bus.m0_ack}); else passed++;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bus.m0_req = 1; bus.m0_addr = 32'h200;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      total++; if ({bus.s_req, bus.m0_ack} !== 2'b10)
        $display("FAIL tmo_wait%0d: got %b want 10", k, {bus.s_req, bus.m0_ack}); else passed++;
    end
    @(negedge clk);
    total++; if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {2'b11, 32'h0})
      $display("FAIL tmo_err: got %h want %h", {bus.m0_ack, bus.m0_err, bus.m0_rdata}, {2'b11, 32'h0}); else passed++;
    bus.s_ack = 1;
    @(negedge clk);
    bus.m0_req = 0;
    total++; if (bus.m0_ack !== 1'b0)
      $display("FAIL tmo_single_pulse: got %b want 0", bus.m0_ack); else passed++;
    @(negedge clk);
    total++; if ({bus.s_req, bus.owner, bus.m0_ack} !== 4'b0000)
      $display("FAIL tmo_late_ack: got %b want 0000", {bus.s_req, bus.owner, bus.m0_ack}); else passed++;
    bus.s_ack = 0;
    // slave ack on the very cycle the limit is reached still wins
    bus.m0_req = 1;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      bus.s_ack = (k == TO - 1); bus.s_rdata = 32'hA5A55A5A;
    end
    @(negedge clk);
    total++; if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {2'b10, 32'hA5A55A5A})
      $display("FAIL tmo_edge_ack: got %h want %h", {bus.m0_ack, bus.m0_err, bus.m0_rdata}, {2'b10, 32'hA5A55A5A}); else passed++;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    bus.m0_req = 1; bus.m0_addr = 32'h300;
    @(negedge clk);
    total++; if (bus.s_req !== 1'b1)
      $display("FAIL rstmid_busy: got %b want 1", bus.s_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.s_req, bus.owner, bus.s_addr, bus.m0_rdata} !== 67'h0)
      $display("FAIL rstmid_async: got %h want 0", {bus.s_req, bus.owner, bus.s_addr, bus.m0_rdata}); else passed++;
    bus.m0_req = 0; bus.s_ack = 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({bus.s_req, bus.m0_ack, bus.m1_ack} !== 3'b000)
        $display("FAIL rstmid_no_ack%0d: got %b want 000", k, {bus.s_req, bus.m0_ack, bus.m1_ack}); else passed++;
    end
    bus.m0_req = 1; bus.m0_addr = 32'h304;
    @(negedge clk);
    total++; if ({bus.s_req, bus.s_addr} !== {1'b1, 32'h304})
      $display("FAIL rstmid_fresh_req: got %h want %h", {bus.s_req, bus.s_addr}, {1'b1, 32'h304}); else passed++;
    bus.s_rdata = 32'h55;
    @(negedge clk);
    total++; if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {2'b10, 32'h55})
      $display("FAIL rstmid_fresh_ack: got %h want %h", {bus.m0_ack, bus.m0_err, bus.m0_rdata}, {2'b10, 32'h55}); else passed++;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        pend[2], we_a[2];
    logic [31:0] ad[2], wd[2], exp_rd[2];
    logic [3:0]  be_a[2];
    logic        lw, w, tmo;
    logic [1:0]  oh;
    logic [31:0] rd;
    int          lat, nb;
    do_reset();
    lw = 1'b1;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; we_a[m] = 0; ad[m] = '0; wd[m] = '0; be_a[m] = '0; exp_rd[m] = '0;
    end
    for (int n = 0; n < 40; n++) begin
      // idle masters may raise a request; at least one master is pending
      for (int m = 0; m < 2; m++)
        if (!pend[m] && (1'($urandom) || (m == 1 && !pend[0]))) begin
          pend[m] = 1; we_a[m] = 1'($urandom); ad[m] = $urandom; wd[m] = $urandom; be_a[m] = 4'($urandom);
        end
      bus.m0_req = pend[0]; bus.m0_we = we_a[0]; bus.m0_addr = ad[0]; bus.m0_wdata = wd[0]; bus.m0_be = be_a[0];
      bus.m1_req = pend[1]; bus.m1_we = we_a[1]; bus.m1_addr = ad[1]; bus.m1_wdata = wd[1]; bus.m1_be = be_a[1];
      bus.s_ack = 1'($urandom); bus.s_rdata = $urandom;
      w   = (pend[0] && pend[1]) ? ~lw : pend[1];
      lw  = w;
      oh  = {w, ~w};
      lat = int'($urandom_range(6, 0));
      tmo = (lat >= TO);
      nb  = tmo ? TO : lat + 1;
      rd  = $urandom;
      for (int k = 0; k < nb; k++) begin
        @(negedge clk);
        total++; if ({bus.s_req, bus.owner, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be, bus.m1_ack, bus.m0_ack}
                     !== {1'b1, oh, we_a[w], ad[w], wd[w], be_a[w], 2'b00})
          $display("FAIL rnd_busy%0d_%0d: got %h want %h", n, k,
                   {bus.s_req, bus.owner, bus.s_we, bus.s_addr, bus.s_wdata, bus.s_be, bus.m1_ack, bus.m0_ack},
                   {1'b1, oh, we_a[w], ad[w], wd[w], be_a[w], 2'b00}); else passed++;
        bus.s_ack   = (k == lat);
        bus.s_rdata = (k == lat) ? rd : $urandom;
        if (k == 0 && ($urandom % 4 == 0)) begin
          pend[w] = 0;
          if (w) bus.m1_req = 0; else bus.m0_req = 0;
        end
      end
      @(negedge clk);
      exp_rd[w] = tmo ? 32'h0 : rd;
      total++; if ({bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err} !== {oh, tmo ? oh : 2'b00})
        $display("FAIL rnd_resp%0d: got %b want %b", n, {bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err}, {oh, tmo ? oh : 2'b00}); else passed++;
      total++; if ({bus.m1_rdata, bus.m0_rdata} !== {exp_rd[1], exp_rd[0]})
        $display("FAIL rnd_rdata%0d: got %h want %h", n, {bus.m1_rdata, bus.m0_rdata}, {exp_rd[1], exp_rd[0]}); else passed++;
      pend[w]   = 0;
      bus.s_ack = 1'($urandom);
      @(negedge clk);
      total++; if ({bus.s_req, bus.owner, bus.m1_ack, bus.m0_ack} !== 5'b00000)
        $display("FAIL rnd_idle%0d: got %b want 00000", n, {bus.s_req, bus.owner, bus.m1_ack, bus.m0_ack}); else passed++;
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the slave-wait cycle limit before an error response; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports mN_req/mN_we, input, 1 each, N in {0,1}; master 0 = core D-bus, master 1 = debug system-bus access.
REQ-005 SHALL have ports mN_addr/mN_wdata, input, 32 each, and mN_be, input, 4, the byte enables.
REQ-006 SHALL have ports mN_ack/mN_err, output, 1 each, and mN_rdata, output, 32, the per-master response.
REQ-007 SHALL have ports s_req/s_we, output, 1; s_addr/s_wdata, output, 32; s_be, output, 4, the shared slave request.
REQ-008 SHALL have ports s_ack, input, 1, and s_rdata, input, 32, the slave response.
REQ-009 SHALL have port owner, output, 2, a one-hot indication of the current grant holder (00 when idle).

Function
REQ-010 SHALL implement states IDLE, BUSY and RESP, held in a register.
REQ-011 Master protocol: a master SHALL hold mN_req and its fields stable until it samples mN_ack=1, and MAY present a new request from the following cycle.
REQ-012 IDLE with exactly one mN_req high SHALL grant that master and go to BUSY.
REQ-013 IDLE with both requests high SHALL grant the master not granted last (round-robin); last_grant resets to 1, so master 0 wins the first tie.
REQ-014 On grant, s_we/s_addr/s_wdata/s_be SHALL be registered from the granted master and held constant through BUSY.
REQ-015 owner SHALL be set on grant and cleared on return to IDLE.
REQ-016 s_req SHALL be high in every BUSY cycle and low in all other states.
REQ-017 Request latency: mN_req in IDLE at cycle t SHALL give s_req=1 at t+1.
REQ-018 s_ack=1 in BUSY at cycle u SHALL capture s_rdata and go to RESP.
REQ-019 In RESP at cycle u+1, the granted mN_ack SHALL be 1 for exactly one cycle with mN_rdata = captured data and mN_err=0; the state SHALL then return to IDLE.
REQ-020 The non-granted master's ack/err SHALL stay 0; its mN_rdata SHALL hold its last value.
REQ-021 Minimum cycle count with a zero-wait slave: req t -> s_req t+1 -> ack t+2; IDLE at t+3 re-arbitrates.
REQ-022 Timeout: a BUSY wait counter (width ceil(log2(TIMEOUT+1))) SHALL clear on grant and increment every BUSY cycle without s_ack.
REQ-023 If TIMEOUT != 0 and the counter reaches TIMEOUT without s_ack, the arbiter SHALL go to RESP with mN_ack=1, mN_err=1 and mN_rdata=32'h0000_0000.
REQ-024 s_ack received in IDLE or RESP, including a late ack after a timeout, SHALL be ignored.
REQ-025 s_ack in the same cycle the counter reaches TIMEOUT SHALL take priority and give a normal, non-error response.
REQ-026 mN_req dropping during BUSY (protocol violation) SHALL NOT abort the transaction; the response SHALL still be issued.
REQ-027 A master re-requesting immediately after its ack SHALL lose to a pending other master under REQ-013.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, last_grant=1, counter=0 and owner=00, and set all outputs to 0, including s_*, mN_ack, mN_err and mN_rdata.
REQ-029 Reset asserted mid-BUSY SHALL drop s_req asynchronously; the in-flight transaction SHALL be lost with no ack after release.
REQ-030 After rst_n deasserts, the first arbitration SHALL occur in the first IDLE clock edge.

Verification
REQ-031 m0 read addr 0x100, slave acks 1 cycle after s_req with rdata 0xCAFEF00D -> m0_ack pulse, m0_rdata=0xCAFEF00D, m0_err=0, m1_ack=0.
REQ-032 m0 and m1 request together from reset -> m0 served first, then m1; held requests alternate m0, m1, m0, and owner follows the grants.
REQ-033 m1 write addr 0x40, wdata 0x12345678, be 0011 -> s_we=1 and s_* match exactly, stable until s_ack.
REQ-034 TIMEOUT=4, slave never acks -> s_req high for 4 cycles, then m0_ack=1, m0_err=1, rdata=0; a later s_ack is ignored.
REQ-035 rst_n pulsed low mid-BUSY -> s_req=0 at once, all outputs 0, no ack after release; a fresh m0 request is served normally.
